// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;
   localparam int NREQ    = 3;
   localparam int REQ_C64 = 0;
   localparam int REQ_DL  = 1;
   localparam int REQ_DMA = 2;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational winner select, C64 first unless its streak is full, else round-robin DL/DMA.
module sdram_arb_pick
   import sdram_arb_pkg::*;
(
   input  logic [NREQ-1:0] i_req,
   input  logic            i_streak_full,
   input  logic            i_rr_last,
   output logic [NREQ-1:0] o_grant,
   output logic            o_any
);
   logic w_c64, w_dl;
   // i_rr_last high means DMA was served last, so DL wins a tie
   assign w_c64   = i_req[REQ_C64] & ~(i_streak_full & (i_req[REQ_DL] | i_req[REQ_DMA]));
   assign w_dl    = i_req[REQ_DL] & (~i_req[REQ_DMA] | i_rr_last);
   assign o_grant = w_c64 ? 3'b001 : w_dl ? 3'b010 : i_req[REQ_DMA] ? 3'b100 : 3'b000;
   assign o_any   = |i_req;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: serialises three requesters onto one SDRAM controller req/ack/done port.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 8,
   parameter int C64_STREAK = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          done,
   output logic [DATA_W-1:0]        rdata,
   output logic                     err,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ack,
   input  logic                     mem_done,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     busy
);
   localparam int SW = $clog2(C64_STREAK + 1);
   state_t          r_state, w_next;
   logic [NREQ-1:0] r_owner, w_grant;
   logic [SW-1:0]   r_streak;
   logic [7:0]      r_wd;
   logic [1:0]      w_idx;
   logic            r_rr_last, w_any, w_others, w_streak_full;
   logic            w_mem_req, w_busy, w_fin;

   assign w_others      = req[REQ_DL] | req[REQ_DMA];
   assign w_streak_full = r_streak == SW'(C64_STREAK);
   assign w_idx         = w_grant[REQ_DMA] ? 2'd2 : {1'b0, w_grant[REQ_DL]};

   sdram_arb_pick u_pick (
      .i_req         (req),
      .i_streak_full (w_streak_full),
      .i_rr_last     (r_rr_last),
      .o_grant       (w_grant),
      .o_any         (w_any)
   );

   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? ISSUE : IDLE;
         ISSUE:   w_next = mem_ack ? WAIT : ISSUE;
         WAIT:    w_next = (mem_done || r_wd == 8'(TIMEOUT)) ? DONE : WAIT;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // outputs are decoded from the next state so they land registered with it
   always_comb begin
      w_mem_req = w_next == ISSUE;
      w_busy    = w_next != IDLE;
      w_fin     = r_state == WAIT && w_next == DONE;
   end

   always_ff @(posedge clk)
      if (reset) begin
         mem_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         r_owner   <= '0;
         r_streak  <= '0;
         r_rr_last <= 1'b1;
         r_wd      <= 8'd0;
      end else begin
         mem_req <= w_mem_req;
         busy    <= w_busy;
         done    <= w_fin ? r_owner : '0;
         err     <= w_fin & ~mem_done;
         r_wd    <= r_state == WAIT ? r_wd + 8'd1 : 8'd0;
         if (w_fin) rdata <= mem_done ? mem_rdata : '0;
         if (r_state == IDLE && w_any) begin
            r_owner   <= w_grant;
            mem_we    <= req_we[w_idx];
            mem_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
            r_streak  <= (!w_grant[REQ_C64] || !w_others) ? '0 : w_streak_full ? r_streak : r_streak + 1'b1;
            if (!w_grant[REQ_C64]) r_rr_last <= w_grant[REQ_DMA];
         end
      end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized and directed bench with a transaction-level model of arbitration and latency.
module tb_sdram_port_arbiter;
   localparam int AW = 25, DW = 8, STREAK = 4, TO = 255;
   logic clk = 1'b0, reset = 1'b1;
   logic [2:0] req = '0, req_we = '0, done;
   logic [3*AW-1:0] req_addr = '0;
   logic [3*DW-1:0] req_wdata = '0;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata = '0;
   logic [AW-1:0] mem_addr;
   logic err, mem_req, mem_we, busy, mem_ack = 1'b0, mem_done = 1'b0;

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .C64_STREAK(STREAK), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit on[3], hold[3], rnd, rst_now, txn, no_done;
   logic [AW-1:0] a_q[3];
   logic we_q[3];
   logic [DW-1:0] wd_q[3];
   int t_dec, t_ack, t_md, t_pulse, free_from, own, ack_wait, done_dly;
   logic [AW-1:0] e_addr;
   logic e_we, e_err, le;
   logic [DW-1:0] e_wdata, e_rdata, lr;
   int c64_run, nxt, ack_cfg, dd_cfg, to_mode, fix_rd;
   int dlog[$];
   int lp, last_ack, mreq_cnt, c0;
   int e2[4] = '{1, 2, 1, 2};
   int e3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   always @(posedge clk)
      if (mem_done) assert (txn && t_ack >= 0 && cyc > t_ack) else $error("controller drove mem_done outside WAIT");

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic new_cmd(int i);
      on[i] = 1'b1;
      a_q[i] = AW'($urandom);
      we_q[i] = 1'($urandom_range(1));
      wd_q[i] = DW'($urandom);
   endtask

   // fixed priority for C64 unless it has had STREAK grants in a row while others waited
   function automatic int pick();
      bit others = on[1] | on[2];
      if (on[0] && !(c64_run >= STREAK && others)) return 0;
      if (on[1] && on[2]) return nxt;
      return on[1] ? 1 : 2;
   endfunction

   task automatic step();
      logic [2:0] s_done;
      logic s_mreq;
      bit eb, em, ep;
      @(negedge clk);
      cyc++;
      eb = txn && cyc > t_dec;
      em = eb && t_ack < 0;
      ep = txn && cyc == t_pulse;
      chk("busy", busy, eb);
      chk("mem_req", mem_req, em);
      if (em) begin
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_we", mem_we, e_we);
         chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("done", done, ep ? 32'(1) << own : 32'(0));
      chk("err", err, ep && e_err);
      if (ep) chk("rdata", rdata, e_rdata);
      s_done = done;
      s_mreq = mem_req;
      mreq_cnt += int'(mem_req);
      if (|done) begin
         dlog.push_back(done[2] ? 2 : done[1] ? 1 : 0);
         lp = cyc;
         lr = rdata;
         le = err;
      end
      if (ep) begin
         txn = 1'b0;
         free_from = cyc + 1;
      end
      for (int i = 0; i < 3; i++)
         if (s_done[i]) begin
            if (hold[i] || (rnd && $urandom_range(1) == 1)) new_cmd(i);
            else on[i] = 1'b0;
         end else if (rnd) begin
            if (!on[i] && $urandom_range(3) == 0) new_cmd(i);
            else if (on[i] && !(txn && own == i) && $urandom_range(15) == 0) on[i] = 1'b0;
         end
      mem_ack = 1'b0;
      mem_done = 1'b0;
      mem_rdata = DW'($urandom);
      if (txn && t_ack < 0 && s_mreq) begin
         if (ack_wait == 0) begin
            mem_ack = 1'b1;
            t_ack = cyc;
            last_ack = cyc;
            if (no_done) begin
               t_pulse = cyc + TO + 2;
               e_err = 1'b1;
               e_rdata = '0;
            end else t_md = cyc + 1 + done_dly;
         end else ack_wait--;
      end else if (txn && t_ack >= 0 && cyc == t_md) begin
         mem_done = 1'b1;
         if (fix_rd >= 0) mem_rdata = DW'(fix_rd);
         e_rdata = mem_rdata;
         e_err = 1'b0;
         t_pulse = cyc + 1;
      end
      if (rst_now) begin
         reset = 1'b1;
         on = '{default: 1'b0};
         txn = 1'b0;
         free_from = cyc + 1;
         c64_run = 0;
         nxt = 1;
         mem_ack = 1'b0;
         mem_done = 1'b0;
      end else begin
         reset = 1'b0;
         if (!txn && cyc >= free_from && (on[0] || on[1] || on[2])) begin
            own = pick();
            if (own == 0) c64_run = (on[1] || on[2]) ? (c64_run < STREAK ? c64_run + 1 : STREAK) : 0;
            else begin
               c64_run = 0;
               nxt = own == 1 ? 2 : 1;
            end
            txn = 1'b1;
            t_dec = cyc;
            t_ack = -1;
            t_md = -1;
            t_pulse = -1;
            e_addr = a_q[own];
            e_we = we_q[own];
            e_wdata = wd_q[own];
            ack_wait = ack_cfg < 0 ? int'($urandom_range(3)) : ack_cfg;
            done_dly = dd_cfg < 0 ? int'($urandom_range(4)) : dd_cfg;
            no_done = to_mode == 1 || (to_mode == 2 && $urandom_range(39) == 0);
         end
      end
      for (int i = 0; i < 3; i++) begin
         req[i] = on[i];
         req_we[i] = we_q[i];
         req_addr[i*AW +: AW] = a_q[i];
         req_wdata[i*DW +: DW] = wd_q[i];
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 2000; n++) begin
         if (!txn && !on[0] && !on[1] && !on[2]) break;
         step();
      end
      chk("drain_idle", {txn, on[0], on[1], on[2]}, 0);
   endtask

   task automatic run_until_log(int n);
      for (int k = 0; k < 600 && dlog.size() < n; k++) step();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         a_q[i] = '0;
         we_q[i] = 1'b0;
         wd_q[i] = '0;
      end
      rst_now = 1'b1;
      free_from = 0;
      nxt = 1;
      ack_cfg = 0;
      dd_cfg = 0;
      to_mode = 0;
      fix_rd = -1;
      repeat (3) step();
      rst_now = 1'b0;
      step();
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);

      // single C64 read, ack at 1, done at 4
      new_cmd(0);
      a_q[0] = 25'h0001234;
      we_q[0] = 1'b0;
      dd_cfg = 2;
      fix_rd = 'h5A;
      c0 = cyc + 1;
      drain();
      chk("p1_pulse_cycle", lp - c0, 5);
      chk("p1_rdata", lr, 8'h5A);
      chk("p1_err", le, 0);
      fix_rd = -1;
      dd_cfg = 0;

      // reset mid-WAIT after three C64 grants, with DL waiting
      hold[0] = 1'b1;
      hold[1] = 1'b1;
      new_cmd(0);
      new_cmd(1);
      dd_cfg = 10;
      dlog.delete();
      for (int k = 0; k < 500 && !(dlog.size() == 2 && txn && t_ack >= 0 && cyc >= t_ack + 2); k++) step();
      hold = '{default: 1'b0};
      rst_now = 1'b1;
      step();
      rst_now = 1'b0;
      dlog.delete();
      repeat (20) step();
      chk("rst_no_done", dlog.size(), 0);
      dd_cfg = 0;

      // C64 and DL both held: streak bound gives DL every fifth grant
      hold[0] = 1'b1;
      hold[1] = 1'b1;
      new_cmd(0);
      new_cmd(1);
      run_until_log(10);
      hold = '{default: 1'b0};
      drain();
      for (int i = 0; i < 10; i++) chk("streak_order", i < dlog.size() ? dlog[i] : -1, e3[i]);

      // fresh DMA request issues one cycle after it is raised
      new_cmd(2);
      step();
      step();
      chk("dma_issue", mem_req, 1);
      chk("dma_addr", mem_addr, a_q[2]);
      drain();

      // DL and DMA held: strict alternation
      hold[1] = 1'b1;
      hold[2] = 1'b1;
      new_cmd(1);
      new_cmd(2);
      dlog.delete();
      run_until_log(4);
      hold = '{default: 1'b0};
      drain();
      for (int i = 0; i < 4; i++) chk("rr_order", i < dlog.size() ? dlog[i] : -1, e2[i]);

      // lost mem_done: watchdog completion then a normal access
      to_mode = 1;
      new_cmd(0);
      drain();
      chk("to_latency", lp - last_ack, TO + 2);
      chk("to_err", le, 1);
      chk("to_rdata", lr, 0);
      to_mode = 0;
      dlog.delete();
      new_cmd(1);
      drain();
      chk("to_next_err", le, 0);
      chk("to_next_owner", dlog.size() == 1 ? dlog[0] : -1, 1);

      // slow ack: mem_req held 7 cycles per access, C64 arriving meanwhile waits
      ack_cfg = 6;
      dd_cfg = 1;
      dlog.delete();
      mreq_cnt = 0;
      new_cmd(1);
      repeat (3) step();
      new_cmd(0);
      drain();
      chk("ack7_mreq_cycles", mreq_cnt, 14);
      chk("ack7_first", dlog.size() == 2 ? dlog[0] : -1, 1);
      chk("ack7_second", dlog.size() == 2 ? dlog[1] : -1, 0);

      // random traffic with occasional timeouts and resets
      rnd = 1'b1;
      ack_cfg = -1;
      dd_cfg = -1;
      to_mode = 2;
      for (int r = 0; r < 3; r++) begin
         repeat (700) step();
         rst_now = 1'b1;
         step();
         rst_now = 1'b0;
      end
      repeat (500) step();
      rnd = 1'b0;
      to_mode = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller command port of the C64 core between three requesters: the C64 bus (CPU/VIC), the data_io download path, and the cartridge/REU DMA engine. Each requester issues one read or write at a time over a level request/done handshake. The block serialises them into the controller's req/ack/done interface and routes completion and read data back to the owner. Fixed priority for the C64 bus, round-robin between the other two, a starvation bound, and a completion watchdog.

## Interface
- ADDR_W, 25, SDRAM byte address width
- DATA_W, 8, data width per access
- C64_STREAK, 4, max consecutive C64 grants while another requester waits
- TIMEOUT, 255, WAIT cycles before a missing mem_done is declared lost (8-bit counter)

- clk  in  1  core clock; sole clock
- reset  in  1  synchronous, active-high
- req  in  3  level request per requester; index 0=C64, 1=download, 2=DMA
- req_we  in  3  1=write, 0=read, per requester
- req_addr  in  3*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  3*DATA_W  packed likewise
- done  out  3  one-cycle completion pulse to owner
- rdata  out  DATA_W  read data, valid while any done bit is high
- err  out  1  high with done when the access timed out
- mem_req  out  1  command valid to SDRAM controller
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  registered copy of the owner's command
- mem_ack  in  1  controller accepted the command (pulse)
- mem_done  in  1  access finished (pulse); for reads, mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  read data from the controller
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**: if any req is high, pick a winner.
  - Latch owner, we, addr and wdata into the mem_* registers.
  - Go to ISSUE.
- **Pick rule**: req[0] wins unless streak == C64_STREAK and req[1]|req[2] is high.
  - Otherwise, between 1 and 2, the one not served last wins.
  - The rr pointer updates only when 1 or 2 is granted.
  - streak increments on a C64 grant while req[1]|req[2] is high, saturating at C64_STREAK.
  - streak clears on any grant to 1 or 2, and on a C64 grant with no other request pending.
- **ISSUE**: mem_req=1 and held until mem_ack. On mem_ack, go to WAIT and clear the watchdog.
- **WAIT**: mem_req=0; the watchdog counts every cycle.
  - On mem_done: capture mem_rdata, go to DONE with err=0.
  - If the watchdog reaches TIMEOUT: go to DONE with err=1 and rdata=0.
- **DONE**: done[owner]=1, err as captured; then IDLE. No arbitration happens in DONE.
- **Requester rules**:
  - Hold req, we, addr and wdata stable from assertion until its done pulse.
  - Drop req no later than the cycle after done.
  - A req high in the cycle after DONE is treated as a new request.
- **Controller assumptions**: mem_done during IDLE, ISSUE or DONE is ignored and flagged by a bench assertion. mem_ack outside ISSUE is likewise ignored.
- **Reset mid-access**: the next state is IDLE. mem_req, done and err are 0, streak is 0 and the rr pointer is 1. The pending access is abandoned, with no done pulse.

## Timing
- Reset values: mem_req=0, done=0, err=0, rdata=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
- All outputs are registered.
- Latency, with req first high in IDLE cycle 0:
  - mem_req is high from cycle 1.
  - With mem_ack in cycle a≥1, WAIT runs from a+1.
  - With mem_done in cycle d, done is high in d+1 and busy is low from d+2.
- Minimum turnaround: req at 0, ack at 1, done at 2, done pulse at 3, next grant decided at 4, next mem_req at 5.
- A req that drops before its grant is not serviced. A req that drops after grant still completes, and its done pulse still fires.

## Structure
- Package sdram_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - requester index constants REQ_C64=0, REQ_DL=1, REQ_DMA=2;
  - NREQ=3.
- Sub-module sdram_arb_pick: combinational winner select.
  - Inputs: req, streak_full, rr_last.
  - Outputs: grant one-hot and any.
  - Streak and rr registers stay in the parent.

## Test plan
- Single C64 read at addr 0x0001234; controller acks at cycle 1 and returns 0x5A on done at cycle 4 → done[0] and rdata=0x5A at cycle 5, err=0, busy low at cycle 6.
- req[1] and req[2] held continuously, each re-raised after its own done → grants alternate 1,2,1,2; rr starts with 1 after reset.
- req[0] held continuously plus req[1] held → grant order 0,0,0,0,1,0,0,0,0,1 with C64_STREAK=4.
- Controller never asserts mem_done → done[owner] and err=1 exactly TIMEOUT+1 cycles after WAIT entry; the next request is then serviced normally.
- reset asserted during WAIT → mem_req=0, no done pulse, streak=0; a fresh req[2] after reset issues mem_req one cycle later.
- mem_ack delayed 7 cycles → mem_req high continuously for 7 cycles with mem_addr/mem_we/mem_wdata stable throughout; a req[0] arriving meanwhile is granted only after done.
